// File: rtl/snn_pkg.sv
// Shared types and arithmetic for the spiking winner-take-all layer.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEAK,
    ACCUM,
    FIRE
  } state_e;

  localparam int POT_MIN = 0;

  function automatic int pot_max(input int pot_w);
    return (1 << (pot_w - 1)) - 1;
  endfunction

  // Potentials never go negative; below-floor results pin to 0.
  function automatic int sat_add(
    input int v,
    input int w,
    input int hi
  );
    int s;
    s = v + w;
    if (s < POT_MIN) return POT_MIN;
    if (s > hi) return hi;
    return s;
  endfunction

endpackage

// File: rtl/lif_unit.sv
// Leaky integrate-and-fire neuron: potential and refractory counter.
module lif_unit
  import snn_pkg::*;
#(
  parameter int POT_W         = 16,
  parameter int WEIGHT_W      = 4,
  parameter int LEAK_SHIFT    = 4,
  parameter int REFRACT_STEPS = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       leak_i,
  input  logic                       acc_i,
  input  logic signed [WEIGHT_W-1:0] weight_i,
  input  logic                       tick_i,
  input  logic                       clear_i,
  input  logic                       load_i,
  output logic [POT_W-1:0]           v_o,
  output logic                       refract_o
);

  localparam int CW =
    REFRACT_STEPS > 0 ? $clog2(REFRACT_STEPS + 1) : 1;
  localparam int VMAX = pot_max(POT_W);

  logic [POT_W-1:0] v_q;
  logic [CW-1:0]    cnt_q;

  assign v_o       = v_q;
  assign refract_o = cnt_q != '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q   <= '0;
      cnt_q <= '0;
    end else begin
      if (leak_i) begin
        v_q <= v_q - (v_q >> LEAK_SHIFT);
      end else if (acc_i && !refract_o) begin
        v_q <= POT_W'(sat_add(int'(v_q), int'(weight_i), VMAX));
      end else if (tick_i && clear_i) begin
        v_q <= '0;
      end
      if (tick_i) begin
        if (load_i) cnt_q <= CW'(REFRACT_STEPS);
        else if (refract_o) cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/snn_wta_layer.sv
// Winner-take-all spiking layer: timestep FSM, weight store, arbitration.
module snn_wta_layer
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS    = 4,
  parameter int NUM_NODES     = 4,
  parameter int WEIGHT_W      = 4,
  parameter int POT_W         = 16,
  parameter int THRESHOLD     = 12000,
  parameter int LEAK_SHIFT    = 4,
  parameter int REFRACT_STEPS = 2,
  localparam int NW = NUM_NODES > 1 ? $clog2(NUM_NODES) : 1,
  localparam int IW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  step_i,
  input  logic [NUM_INPUTS-1:0] spikes_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [NW-1:0]         wr_node_i,
  input  logic [IW-1:0]         wr_input_i,
  input  logic [WEIGHT_W-1:0]   wr_weight_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  spike_o,
  output logic [NW-1:0]         winner_o,
  output logic                  overrun_o
);

  state_e                  state_q;
  logic [NUM_INPUTS-1:0]   spk_q;
  logic [IW-1:0]           idx_q;
  logic [NW-1:0]           winner_q;
  logic                    overrun_q;
  logic signed [WEIGHT_W-1:0] w_q [NUM_NODES][NUM_INPUTS];

  logic [POT_W-1:0]     v [NUM_NODES];
  logic [NUM_NODES-1:0] refr;
  logic                 has_win;
  logic [NW-1:0]        win_idx;
  logic [POT_W-1:0]     best;
  logic                 leak, acc, tick, wr_go;

  assign leak = state_q == LEAK;
  assign acc  = (state_q == ACCUM) && spk_q[idx_q];
  assign tick = state_q == FIRE;

  assign busy_o     = state_q != IDLE;
  assign wr_ready_o = state_q == IDLE;
  assign done_o     = tick;
  assign spike_o    = tick && has_win;
  assign winner_o   = spike_o ? win_idx : winner_q;
  assign overrun_o  = overrun_q;

  assign wr_go = wr_valid_i && wr_ready_o
              && int'(wr_node_i) < NUM_NODES
              && int'(wr_input_i) < NUM_INPUTS;

  for (genvar n = 0; n < NUM_NODES; n++) begin : g_node
    lif_unit #(
      .POT_W        (POT_W),
      .WEIGHT_W     (WEIGHT_W),
      .LEAK_SHIFT   (LEAK_SHIFT),
      .REFRACT_STEPS(REFRACT_STEPS)
    ) u_lif (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .leak_i   (leak),
      .acc_i    (acc),
      .weight_i (w_q[n][idx_q]),
      .tick_i   (tick),
      .clear_i  (has_win),
      .load_i   (has_win && win_idx == NW'(n)),
      .v_o      (v[n]),
      .refract_o(refr[n])
    );
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    has_win = 1'b0;
    win_idx = '0;
    best    = '0;
    for (int n = 0; n < NUM_NODES; n++) begin
      if (!refr[n] && int'(v[n]) >= THRESHOLD
          && (!has_win || v[n] > best)) begin
        has_win = 1'b1;
        win_idx = NW'(n);
        best    = v[n];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int n = 0; n < NUM_NODES; n++)
        for (int i = 0; i < NUM_INPUTS; i++)
          w_q[n][i] <= '0;
    end else if (wr_go) begin
      w_q[wr_node_i][wr_input_i] <= wr_weight_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      spk_q     <= '0;
      idx_q     <= '0;
      winner_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (step_i && state_q != IDLE) overrun_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (step_i) begin
            spk_q   <= spikes_i;
            state_q <= LEAK;
          end
        end
        LEAK: begin
          idx_q   <= '0;
          state_q <= ACCUM;
        end
        ACCUM: begin
          if (idx_q == IW'(NUM_INPUTS - 1)) state_q <= FIRE;
          else idx_q <= idx_q + 1'b1;
        end
        FIRE: begin
          if (has_win) winner_q <= win_idx;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snn_wta_layer.sv
// Directed bench: a THRESHOLD=20 layer plus an 8-bit saturation layer.
module tb_snn_wta_layer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic [3:0]  spikes = '0;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_node = '0;
  logic [1:0]  wr_input = '0;
  logic [3:0]  wr_weight = '0;

  logic       a_ready, a_busy, a_done, a_spike, a_ovr;
  logic [1:0] a_winner;
  logic       b_ready, b_busy, b_done, b_spike, b_ovr;
  logic [1:0] b_winner;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (a_done) done_cnt <= done_cnt + 1;

  snn_wta_layer #(.THRESHOLD(20)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .step_i(step), .spikes_i(spikes),
    .wr_valid_i(wr_valid), .wr_ready_o(a_ready),
    .wr_node_i(wr_node), .wr_input_i(wr_input),
    .wr_weight_i(wr_weight), .busy_o(a_busy), .done_o(a_done),
    .spike_o(a_spike), .winner_o(a_winner), .overrun_o(a_ovr)
  );

  snn_wta_layer #(.POT_W(8), .THRESHOLD(200)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .step_i(step), .spikes_i(spikes),
    .wr_valid_i(wr_valid), .wr_ready_o(b_ready),
    .wr_node_i(wr_node), .wr_input_i(wr_input),
    .wr_weight_i(wr_weight), .busy_o(b_busy), .done_o(b_done),
    .spike_o(b_spike), .winner_o(b_winner), .overrun_o(b_ovr)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    step = 1'b0;
    wr_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_w(input int n, input int i, input int w);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_node = 2'(n);
    wr_input = 2'(i);
    wr_weight = 4'(w);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic write_all(input int w0, input int w1,
                           input int w2, input int w3);
    for (int i = 0; i < 4; i++) begin
      write_w(0, i, w0);
      write_w(1, i, w1);
      write_w(2, i, w2);
      write_w(3, i, w3);
    end
  endtask

  // Returns in the done cycle; lat counts cycles after the step_i cycle.
  task automatic do_step(input logic [3:0] sp, output int lat,
                         output int spk, output int win);
    @(negedge clk);
    step = 1'b1;
    spikes = sp;
    @(negedge clk);
    step = 1'b0;
    lat = 1;
    while (!a_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    spk = int'(a_spike);
    win = int'(a_winner);
  endtask

  int lat, spk, win, d0;

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_ready", a_ready, 1);
    check_eq("rst_done", a_done, 0);
    check_eq("rst_spike", a_spike, 0);
    check_eq("rst_winner", a_winner, 0);
    check_eq("rst_overrun", a_ovr, 0);

    // Accumulate and fire
    write_all(7, 7, 7, 7);
    do_step(4'b1111, lat, spk, win);
    check_eq("acc_latency", lat, 6);
    check_eq("acc_spike", spk, 1);
    check_eq("acc_winner", win, 0);
    check_eq("acc_v0", int'(dut_a.g_node[0].u_lif.v_q), 28);
    check_eq("acc_v3", int'(dut_a.g_node[3].u_lif.v_q), 28);
    @(negedge clk);
    check_eq("clr_v0", int'(dut_a.g_node[0].u_lif.v_q), 0);
    check_eq("clr_v2", int'(dut_a.g_node[2].u_lif.v_q), 0);
    check_eq("clr_busy", a_busy, 0);

    // Refractory rotation
    do_step(4'b1111, lat, spk, win);
    check_eq("ref1_winner", win, 1);
    check_eq("ref1_v0", int'(dut_a.g_node[0].u_lif.v_q), 0);
    do_step(4'b1111, lat, spk, win);
    check_eq("ref2_winner", win, 2);
    do_step(4'b1111, lat, spk, win);
    check_eq("ref3_spike", spk, 1);
    check_eq("ref3_winner", win, 0);

    do_reset();
    check_eq("rst_weight", int'(dut_a.w_q[2][3]), 0);

    // Weighted winner and tie-break
    write_all(1, 1, 7, 1);
    do_step(4'b1111, lat, spk, win);
    check_eq("wgt_spike", spk, 1);
    check_eq("wgt_winner", win, 2);
    do_reset();
    write_all(7, 1, 7, 1);
    do_step(4'b1111, lat, spk, win);
    check_eq("tie_winner", win, 0);
    do_step(4'b0000, lat, spk, win);
    check_eq("nospk_latency", lat, 6);
    check_eq("nospk_spike", spk, 0);

    // Saturation ceiling and floor on the 8-bit layer
    do_reset();
    write_all(7, 7, 7, 7);
    for (int k = 0; k < 8; k++) do_step(4'b1111, lat, spk, win);
    check_eq("sat_v0", int'(dut_b.g_node[0].u_lif.v_q), 127);
    check_eq("sat_v3", int'(dut_b.g_node[3].u_lif.v_q), 127);
    check_eq("sat_spike", b_spike, 0);
    write_all(-8, -8, -8, -8);
    for (int k = 0; k < 6; k++) do_step(4'b1111, lat, spk, win);
    check_eq("floor_v0", int'(dut_b.g_node[0].u_lif.v_q), 0);
    check_eq("floor_spike", b_spike, 0);

    // Handshake while busy
    do_reset();
    write_all(7, 7, 7, 7);
    d0 = done_cnt;
    @(negedge clk);
    step = 1'b1;
    spikes = 4'b1111;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    check_eq("hs_busy", a_busy, 1);
    step = 1'b1;
    wr_valid = 1'b1;
    wr_node = 2'd1;
    wr_input = 2'd1;
    wr_weight = 4'(-3);
    #1;
    check_eq("hs_ready", a_ready, 0);
    @(negedge clk);
    step = 1'b0;
    wr_valid = 1'b0;
    check_eq("hs_overrun", a_ovr, 1);
    for (int k = 0; k < 15; k++) @(negedge clk);
    check_eq("hs_done_cnt", done_cnt - d0, 1);
    check_eq("hs_idle", a_busy, 0);
    check_eq("hs_weight", int'(dut_a.w_q[1][1]), 7);
    check_eq("hs_ovr_sticky", a_ovr, 1);

    // Mid-step reset
    do_reset();
    write_all(0, 0, 0, 7);
    do_step(4'b1111, lat, spk, win);
    check_eq("mid_pre_winner", win, 3);
    do_step(4'b0000, lat, spk, win);
    check_eq("hold_winner", win, 3);
    @(negedge clk);
    step = 1'b1;
    spikes = 4'b1111;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check_eq("mid_ovr_set", a_ovr, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_busy", a_busy, 0);
    check_eq("mid_done", a_done, 0);
    check_eq("mid_winner", a_winner, 0);
    check_eq("mid_overrun", a_ovr, 0);
    check_eq("mid_v3", int'(dut_a.g_node[3].u_lif.v_q), 0);
    check_eq("mid_weight", int'(dut_a.w_q[3][0]), 0);
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) @(negedge clk);
    check_eq("mid_no_done", done_cnt - d0, 0);
    do_step(4'b1111, lat, spk, win);
    check_eq("fresh_latency", lat, 6);
    check_eq("fresh_spike", spk, 0);
    check_eq("fresh_winner", win, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
